// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default widths,
// active-low reset levels and the enable/zero encodings used by the
// storage, forwarding and scoreboard logic.
// Optional build macro: REGFILE_PERF_CNT_EN (adds forwarding/stall counters).
package regfile_mp_pkg;

    localparam int REG_FILE_ADDR_W = 5;
    localparam int REG_FILE_DATA_W = 32;
    localparam int PERF_CNT_W      = 32;

    localparam logic RST_ENABLE_N  = 1'b0;
    localparam logic RST_DISABLE_N = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic READ_ENABLE   = 1'b1;

    localparam logic [PERF_CNT_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the ID-side read/issue signals and the WB-side write signals
// of the register file. The master drives requests; the slave (register
// file) returns read data, busy flags and the scoreboard snapshot.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = REG_FILE_DATA_W,
    parameter int ADDR_W = REG_FILE_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [2**ADDR_W-1:0]     busy_vec;

    modport master (
        output re, raddr, we, waddr, wdata, iss_en, iss_addr,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  re, raddr, we, waddr, wdata, iss_en, iss_addr,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard. An issue marks its destination busy, any
// writeback to a register clears it; a same-cycle issue wins because the
// new producer supersedes the retiring one. Register 0 is never busy.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = REG_FILE_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] set_next;
    logic [NUM_REGS-1:0] clr_next;

    // Decode issue (set) and writeback (clear) strobes per register; r0 excluded.
    always_comb begin
        set_next = '0;
        clr_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (iss_en && iss_addr == ADDR_W'(i))
                set_next[i] = 1'b1;
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] == WRITE_ENABLE && waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(i))
                    clr_next[i] = 1'b1;
            end
        end
    end

    // Busy vector update: set has priority over clear, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N)
            busy_reg <= '0;
        else
            busy_reg <= set_next | (busy_reg & ~clr_next);
    end

    assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file between ID and WB: NUM_RD combinational
// read ports with same-cycle write forwarding, NUM_WR prioritised write
// ports (higher index wins) and a busy scoreboard for RAW detection.
// Optional build macro: REGFILE_PERF_CNT_EN adds fwd_cnt/stall_cnt outputs.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = REG_FILE_DATA_W,
    parameter int ADDR_W = REG_FILE_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_if.slave     bus
`ifdef REGFILE_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] fwd_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_data [NUM_REGS];

    // Resolve write ports per register; ascending scan lets the highest port win.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_data[i] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (i != 0 && bus.we[j] == WRITE_ENABLE &&
                    bus.waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    wr_hit[i]  = 1'b1;
                    wr_data[i] = bus.wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register storage; r0 never has a write hit so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_hit[i])
                    regs[i] <= wr_data[i];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .we       (bus.we),
        .waddr    (bus.waddr),
        .busy_vec (bus.busy_vec)
    );

`ifdef REGFILE_PERF_CNT_EN
    logic [NUM_RD-1:0] fwd_take;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              rd_ok;
            logic              fwd_hit;
            logic [DATA_W-1:0] fwd_data;
            logic [DATA_W-1:0] rd;
            logic              rb;

            assign ra    = bus.raddr[gi*ADDR_W +: ADDR_W];
            assign rd_ok = (rst != RST_ENABLE_N) && (bus.re[gi] == READ_ENABLE) && (ra != '0);

            // Forwarding match against this cycle's writes; highest port wins.
            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.we[j] == WRITE_ENABLE && bus.waddr[j*ADDR_W +: ADDR_W] == ra) begin
                        fwd_hit  = 1'b1;
                        fwd_data = bus.wdata[j*DATA_W +: DATA_W];
                    end
                end
            end

            // Read priority: disabled/r0/reset -> 0, then forward, then storage + busy.
            always_comb begin
                rd = '0;
                rb = 1'b0;
                if (rd_ok) begin
                    if (fwd_hit) begin
                        rd = fwd_data;
                    end else begin
                        rd = regs[ra];
                        rb = bus.busy_vec[ra];
                    end
                end
            end

            assign bus.rdata[gi*DATA_W +: DATA_W] = rd;
            assign bus.rbusy[gi]                  = rb;
`ifdef REGFILE_PERF_CNT_EN
            assign fwd_take[gi] = rd_ok && fwd_hit;
`endif
        end
    endgenerate

`ifdef REGFILE_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] fwd_inc;

    // Number of read ports served by forwarding this cycle.
    always_comb begin
        fwd_inc = '0;
        for (int k = 0; k < NUM_RD; k++)
            fwd_inc = fwd_inc + PERF_CNT_W'(fwd_take[k]);
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            fwd_cnt   <= ZERO_WORD;
            stall_cnt <= ZERO_WORD;
        end else begin
            fwd_cnt <= fwd_cnt + fwd_inc;
            if (|bus.rbusy)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write/dual-read integer register file.
- Provides NUM_RD combinational read ports, NUM_WR synchronous write ports with priority resolution, and same-cycle write-to-read forwarding.
- Adds a per-register busy scoreboard that ID uses to detect RAW hazards against in-flight writebacks.
- Sits between ID (read/issue side) and WB (write side) of the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; same packing as raddr.
- rbusy  out  NUM_RD  per read port: the addressed register awaits a write.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses.
- wdata  in  NUM_WR*DATA_W  write data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- busy_vec  out  2**ADDR_W  scoreboard snapshot; bit 0 is always 0.

Behaviour:
- Reset (rst=0, async):
  - All registers clear to 0; no initial-block preload.
  - All busy bits clear.
  - rdata=0 and rbusy=0 combinationally while reset is held.
- Write, at posedge clk:
  - Each port with we[j]=1 and waddr[j]!=0 writes wdata[j].
  - When several enabled ports share an address, the highest j wins.
  - Writes to address 0 are dropped.
- Read (combinational, 0-cycle latency), priority order for port k:
  - re[k]=0 -> rdata=0, rbusy=0.
  - raddr[k]=0 -> rdata=0, rbusy=0.
  - Some we[j] matches raddr[k] -> rdata = wdata of the highest matching j (forwarding), rbusy=0.
  - Otherwise -> rdata = stored value, rbusy = busy[raddr[k]].
- Scoreboard, per register i, at posedge:
  - clr_i = any we[j] with waddr[j]=i.
  - set_i = iss_en and iss_addr=i.
  - set_i=1 -> busy[i]=1 (set beats a simultaneous clear, since a new producer supersedes).
  - Else clr_i=1 -> busy[i]=0.
  - Else busy[i] holds.
  - busy[0] is constant 0; iss_addr=0 is ignored.
- Scoreboard side-effects:
  - A write clears busy regardless of how many issues are outstanding; single-outstanding-writer per register is the pipeline's contract.
  - A write to a non-busy register is legal and leaves busy at 0.
- Reset mid-operation: state clears immediately; pending writes that cycle are lost.
- Resource sharing: no port-count-dependent stalls; all NUM_RD reads and NUM_WR writes complete every cycle.

Optional Feature:
- Macro: REGFILE_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs fwd_cnt and stall_cnt, both reset to 0 and wrapping at 2**32.
  - fwd_cnt increments by the number of read ports that took the forwarding path in the cycle.
  - stall_cnt increments by 1 in any cycle where some rbusy is 1.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- defines.v gains:
  - RegFileAddrW and RegFileDataW defaults.
  - Active-low RstEnable_n/RstDisable_n equivalents.
  - Existing WriteEnable, ReadEnable and ZeroWord reused.
- One sub-module, regfile_scoreboard:
  - Holds the busy vector and the set/clear priority logic.
  - Inputs: clk, rst, iss_en, iss_addr, we, waddr.
  - Output: busy_vec.
- Storage, write priority, forwarding and perf counters stay in regfile_mp.

Test Plan:
- Reset, then read all 32 registers on both ports -> every rdata=0 and busy_vec=0; register 1 holds no preload.
- we=2'b11, waddr={5,5}, wdata={0xBBBB (port1), 0xAAAA (port0)}; next cycle read r5 -> 0xBBBB; same-cycle read of r5 also returns 0xBBBB via forwarding.
- Write r0=0xFFFF_FFFF, then read r0 -> 0. Issue to r0 -> busy_vec[0] stays 0.
- Issue r7 -> next cycle rbusy=1 when reading r7. Write r7=0x1234 -> rbusy=0 with rdata=0x1234 that cycle; busy[7]=0 the cycle after.
- Same cycle iss_en with iss_addr=9 and we[0] with waddr=9 -> busy[9]=1 afterwards; r9 holds the written data.
- Pulse rst low between clock edges while busy[3]=1 and r3=0x55 -> immediate rdata=0; after release r3=0, busy[3]=0. With REGFILE_PERF_CNT_EN, the counters also read 0.
